// File: rtl/mac_req_arbiter_if.sv
// Signal bundle between the MAC request/write-data channels, the arbiter and the SDRAM scheduler.
// Signal names follow the arbiter's external pin names; modport directions are from each side's view.
interface mac_req_arbiter_if;
    logic        iRd_Valid;
    logic [31:0] iRd_Addr;
    logic [3:0]  iRd_Tag;
    logic [2:0]  iRd_Id;
    logic [1:0]  iRd_Len;
    logic [3:0]  iRd_QoS;
    logic        oRd_Ready;

    logic        iWr_Valid;
    logic [31:0] iWr_Addr;
    logic [3:0]  iWr_Tag;
    logic [2:0]  iWr_Id;
    logic [1:0]  iWr_Len;
    logic [3:0]  iWr_QoS;
    logic        oWr_Ready;

    logic        iWrD_Valid;
    logic [31:0] iWrD_Data;
    logic [3:0]  iWrD_Mask;
    logic        iWrD_EoD;
    logic        oWrD_Ready;

    logic        oCmd_Valid;
    logic        oCmd_Write;
    logic [31:0] oCmd_Addr;
    logic [3:0]  oCmd_Tag;
    logic [2:0]  oCmd_Id;
    logic [1:0]  oCmd_Len;
    logic        iCmd_Ready;

    logic        oWD_Valid;
    logic [31:0] oWD_Data;
    logic [3:0]  oWD_Mask;
    logic        oWD_EoD;
    logic        iWD_Ready;

    logic        oErr_Len;
    logic        oBusy;

    modport slave (
        input  iRd_Valid, iRd_Addr, iRd_Tag, iRd_Id, iRd_Len, iRd_QoS,
        input  iWr_Valid, iWr_Addr, iWr_Tag, iWr_Id, iWr_Len, iWr_QoS,
        input  iWrD_Valid, iWrD_Data, iWrD_Mask, iWrD_EoD,
        input  iCmd_Ready, iWD_Ready,
        output oRd_Ready, oWr_Ready, oWrD_Ready,
        output oCmd_Valid, oCmd_Write, oCmd_Addr, oCmd_Tag, oCmd_Id, oCmd_Len,
        output oWD_Valid, oWD_Data, oWD_Mask, oWD_EoD,
        output oErr_Len, oBusy
    );

    modport master (
        output iRd_Valid, iRd_Addr, iRd_Tag, iRd_Id, iRd_Len, iRd_QoS,
        output iWr_Valid, iWr_Addr, iWr_Tag, iWr_Id, iWr_Len, iWr_QoS,
        output iWrD_Valid, iWrD_Data, iWrD_Mask, iWrD_EoD,
        output iCmd_Ready, iWD_Ready,
        input  oRd_Ready, oWr_Ready, oWrD_Ready,
        input  oCmd_Valid, oCmd_Write, oCmd_Addr, oCmd_Tag, oCmd_Id, oCmd_Len,
        input  oWD_Valid, oWD_Data, oWD_Mask, oWD_EoD,
        input  oErr_Len, oBusy
    );
endinterface

// File: rtl/mac_req_arbiter.sv
// Read/write request arbiter for the SDRAM command scheduler: QoS first, round-robin on ties,
// starvation override, then pass-through of write data beats until EoD.
//
//   state | meaning
//   IDLE  | arbitrate read/write requests, accept the winner
//   CMD   | hold registered command until the scheduler takes it
//   WDATA | forward write data beats until the accepted EoD beat
module mac_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    mac_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             rp_q, rp_d;
    logic             cmd_write_q, cmd_write_d;
    logic [31:0]      cmd_addr_q, cmd_addr_d;
    logic [3:0]       cmd_tag_q, cmd_tag_d;
    logic [2:0]       cmd_id_q, cmd_id_d;
    logic [1:0]       cmd_len_q, cmd_len_d;
    logic [2:0]       beat_q, beat_d;
    logic             err_q, err_d;

    logic             in_idle;
    logic             in_wdata;
    logic             both_v;
    logic             pick_wr;
    logic             tie;
    logic             grant_rd;
    logic             grant_wr;
    logic             beat_fire;
    logic [2:0]       beat_inc;
    logic [2:0]       exp_beats;

    // Arbitration; rp_q = 0 means the read channel wins the next QoS tie.
    always_comb begin
        pick_wr = 1'b0;
        tie     = 1'b0;
        in_idle = (state_q == IDLE) && !reset;
        both_v  = bus.iRd_Valid && bus.iWr_Valid;
        if (!bus.iRd_Valid) begin
            pick_wr = bus.iWr_Valid;
        end else if (bus.iWr_Valid) begin
            if (rd_cnt_q == LIMIT) begin
                pick_wr = 1'b0;
            end else if (wr_cnt_q == LIMIT) begin
                pick_wr = 1'b1;
            end else if (bus.iRd_QoS != bus.iWr_QoS) begin
                pick_wr = (bus.iWr_QoS > bus.iRd_QoS);
            end else begin
                pick_wr = rp_q;
                tie     = 1'b1;
            end
        end
        grant_rd = in_idle && bus.iRd_Valid && !pick_wr;
        grant_wr = in_idle && bus.iWr_Valid && pick_wr;
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rp_d     = rp_q;
        if (state_q == IDLE) begin
            if (both_v) begin
                if (pick_wr) begin
                    wr_cnt_d = '0;
                    rd_cnt_d = (rd_cnt_q >= LIMIT) ? LIMIT : rd_cnt_q + 1'b1;
                end else begin
                    rd_cnt_d = '0;
                    wr_cnt_d = (wr_cnt_q >= LIMIT) ? LIMIT : wr_cnt_q + 1'b1;
                end
                if (tie) begin
                    rp_d = ~rp_q;
                end
            end else begin
                rd_cnt_d = '0;
                wr_cnt_d = '0;
            end
        end
    end

    always_comb begin
        exp_beats = 3'd1;
        case (cmd_len_q)
            2'b10:   exp_beats = 3'd2;
            2'b11:   exp_beats = 3'd4;
            default: exp_beats = 3'd1;
        endcase
        in_wdata  = (state_q == WDATA);
        beat_fire = in_wdata && bus.iWrD_Valid && bus.iWD_Ready;
        // Saturate so an over-long burst can never wrap back onto a legal count.
        beat_inc  = (beat_q == 3'd7) ? 3'd7 : beat_q + 3'd1;
    end

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_tag_d   = cmd_tag_q;
        cmd_id_d    = cmd_id_q;
        cmd_len_d   = cmd_len_q;
        beat_d      = beat_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_d     = CMD;
                    cmd_write_d = grant_wr;
                    cmd_addr_d  = grant_wr ? bus.iWr_Addr : bus.iRd_Addr;
                    cmd_tag_d   = grant_wr ? bus.iWr_Tag  : bus.iRd_Tag;
                    cmd_id_d    = grant_wr ? bus.iWr_Id   : bus.iRd_Id;
                    cmd_len_d   = grant_wr ? bus.iWr_Len  : bus.iRd_Len;
                end
            end
            CMD: begin
                if (bus.iCmd_Ready) begin
                    state_d = cmd_write_q ? WDATA : IDLE;
                    beat_d  = '0;
                end
            end
            WDATA: begin
                if (beat_fire) begin
                    beat_d = beat_inc;
                    if (bus.iWrD_EoD) begin
                        state_d = IDLE;
                        if (beat_inc != exp_beats) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            rp_q        <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_tag_q   <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rp_q        <= rp_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_tag_q   <= cmd_tag_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
        end
    end

    assign bus.oRd_Ready  = grant_rd;
    assign bus.oWr_Ready  = grant_wr;
    assign bus.oCmd_Valid = (state_q == CMD);
    assign bus.oCmd_Write = cmd_write_q;
    assign bus.oCmd_Addr  = cmd_addr_q;
    assign bus.oCmd_Tag   = cmd_tag_q;
    assign bus.oCmd_Id    = cmd_id_q;
    assign bus.oCmd_Len   = cmd_len_q;
    assign bus.oWD_Valid  = in_wdata && bus.iWrD_Valid;
    assign bus.oWD_Data   = in_wdata ? bus.iWrD_Data : '0;
    assign bus.oWD_Mask   = in_wdata ? bus.iWrD_Mask : '0;
    assign bus.oWD_EoD    = in_wdata && bus.iWrD_EoD;
    assign bus.oWrD_Ready = in_wdata && bus.iWD_Ready;
    assign bus.oErr_Len   = err_q;
    assign bus.oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_req_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the arbitration rules.
module tb_mac_req_arbiter;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    int   m_rd_cnt = 0;
    int   m_wr_cnt = 0;
    bit   m_rp     = 1'b0;
    bit   m_err    = 1'b0;

    mac_req_arbiter_if bus();

    mac_req_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int beats_of(input logic [1:0] len);
        case (len)
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 1;
        endcase
    endfunction

    // Returns 0 = no grant, 1 = read, 2 = write, and advances the model's fairness state.
    task automatic model_arb(input bit rv, input bit wv, input int rq, input int wq, output int win);
        bit tie;
        tie = 1'b0;
        if (rv && wv) begin
            if (m_rd_cnt == STARVE)      win = 1;
            else if (m_wr_cnt == STARVE) win = 2;
            else if (rq != wq)           win = (rq > wq) ? 1 : 2;
            else begin
                win = m_rp ? 2 : 1;
                tie = 1'b1;
            end
            if (win == 1) begin
                m_rd_cnt = 0;
                m_wr_cnt = (m_wr_cnt < STARVE) ? m_wr_cnt + 1 : STARVE;
            end else begin
                m_wr_cnt = 0;
                m_rd_cnt = (m_rd_cnt < STARVE) ? m_rd_cnt + 1 : STARVE;
            end
            if (tie) m_rp = !m_rp;
        end else begin
            win = rv ? 1 : (wv ? 2 : 0);
            m_rd_cnt = 0;
            m_wr_cnt = 0;
        end
    endtask

    task automatic do_txn(input bit rv, input logic [3:0] rq, input bit wv, input logic [3:0] wq,
                          input logic [31:0] waddr, input logic [1:0] wlen, input int nbeats,
                          input int cstall, input int dstall);
        int          win;
        logic [31:0] ra, d;
        logic [3:0]  rt, wt, m;
        logic [2:0]  rid, wid;
        logic [1:0]  rl;
        ra  = $urandom;
        rt  = 4'($urandom);
        rid = 3'($urandom);
        rl  = 2'($urandom);
        wt  = 4'($urandom);
        wid = 3'($urandom);
        bus.iRd_Valid = rv; bus.iRd_Addr = ra; bus.iRd_Tag = rt; bus.iRd_Id = rid;
        bus.iRd_Len = rl;   bus.iRd_QoS = rq;
        bus.iWr_Valid = wv; bus.iWr_Addr = waddr; bus.iWr_Tag = wt; bus.iWr_Id = wid;
        bus.iWr_Len = wlen; bus.iWr_QoS = wq;
        #1;
        model_arb(rv, wv, int'(rq), int'(wq), win);
        chk("rd_ready", bus.oRd_Ready, win == 1);
        chk("wr_ready", bus.oWr_Ready, win == 2);
        chk("busy_idle", bus.oBusy, 0);
        tick();
        if (win == 0) return;
        for (int i = 0; i <= cstall; i++) begin
            bus.iCmd_Ready = (i == cstall);
            #1;
            chk("cmd_valid", bus.oCmd_Valid, 1);
            chk("cmd_write", bus.oCmd_Write, win == 2);
            chk("cmd_addr", bus.oCmd_Addr, (win == 2) ? waddr : ra);
            chk("cmd_tag", bus.oCmd_Tag, (win == 2) ? wt : rt);
            chk("cmd_id", bus.oCmd_Id, (win == 2) ? wid : rid);
            chk("cmd_len", bus.oCmd_Len, (win == 2) ? wlen : rl);
            chk("no_grant_cmd", {bus.oRd_Ready, bus.oWr_Ready}, 0);
            chk("wd_idle", bus.oWD_Valid, 0);
            tick();
        end
        bus.iCmd_Ready = 1'b0;
        if (win == 2) begin
            for (int b = 0; b < nbeats; b++) begin
                d = $urandom;
                m = 4'($urandom);
                bus.iWrD_Valid = 1'b1; bus.iWrD_Data = d; bus.iWrD_Mask = m;
                bus.iWrD_EoD = (b == nbeats - 1);
                for (int s = 0; s <= dstall; s++) begin
                    bus.iWD_Ready = (s == dstall);
                    #1;
                    chk("wd_valid", bus.oWD_Valid, 1);
                    chk("wd_data", bus.oWD_Data, d);
                    chk("wd_mask", bus.oWD_Mask, m);
                    chk("wd_eod", bus.oWD_EoD, b == nbeats - 1);
                    chk("wrd_ready", bus.oWrD_Ready, s == dstall);
                    chk("no_grant_wd", {bus.oRd_Ready, bus.oWr_Ready, bus.oCmd_Valid}, 0);
                    tick();
                end
            end
            bus.iWrD_Valid = 1'b0; bus.iWrD_EoD = 1'b0; bus.iWD_Ready = 1'b0;
            if (nbeats != beats_of(wlen)) m_err = 1'b1;
        end
        #1;
        chk("busy_done", bus.oBusy, 0);
        chk("cmd_valid_done", bus.oCmd_Valid, 0);
        chk("err_len", bus.oErr_Len, m_err);
    endtask

    initial begin
        int win;
        reset = 1'b1;
        bus.iRd_Valid = 0; bus.iRd_Addr = 0; bus.iRd_Tag = 0; bus.iRd_Id = 0; bus.iRd_Len = 0;
        bus.iRd_QoS = 0;
        bus.iWr_Valid = 0; bus.iWr_Addr = 0; bus.iWr_Tag = 0; bus.iWr_Id = 0; bus.iWr_Len = 0;
        bus.iWr_QoS = 0;
        bus.iWrD_Valid = 0; bus.iWrD_Data = 0; bus.iWrD_Mask = 0; bus.iWrD_EoD = 0;
        bus.iCmd_Ready = 0; bus.iWD_Ready = 0;
        tick(); tick();
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_cmd", {bus.oCmd_Valid, bus.oCmd_Write, bus.oCmd_Len, bus.oErr_Len}, 0);
        chk("rst_wd", {bus.oWD_Valid, bus.oWrD_Ready}, 0);
        reset = 1'b0;
        tick();

        // Single write, Len=10, two beats, immediate scheduler ready.
        do_txn(0, 4'd0, 1, 4'b0110, 32'h2345_F220, 2'b10, 2, 0, 0);
        // QoS: write (9) beats read (2); read then granted alone.
        do_txn(1, 4'd2, 1, 4'd9, $urandom, 2'b01, 1, 0, 0);
        do_txn(1, 4'd2, 0, 4'd0, 0, 2'b00, 0, 0, 0);
        // Equal QoS, round robin.
        for (int i = 0; i < 4; i++) do_txn(1, 4'd5, 1, 4'd5, $urandom, 2'b00, 1, 0, 0);
        // Starvation: write loses four times then wins.
        for (int i = 0; i < 5; i++) do_txn(1, 4'd15, 1, 4'd0, $urandom, 2'b01, 1, 0, 0);
        // Len 11 ended after 2 beats, with command and data backpressure.
        do_txn(0, 4'd0, 1, 4'd3, $urandom, 2'b11, 2, 2, 3);

        // Reset in the middle of a 2-beat write burst.
        bus.iRd_Valid = 0; bus.iWr_Valid = 1; bus.iWr_Len = 2'b10; bus.iWr_Addr = $urandom;
        #1;
        model_arb(0, 1, 0, 0, win);
        chk("mid_wr_ready", bus.oWr_Ready, win == 2);
        tick();
        bus.iWr_Valid = 0; bus.iCmd_Ready = 1;
        tick();
        bus.iCmd_Ready = 0;
        bus.iWrD_Valid = 1; bus.iWrD_Data = 32'hABCD_EF12; bus.iWrD_Mask = 4'b1101;
        bus.iWD_Ready = 1;
        #1;
        chk("mid_beat1", bus.oWD_Data, 32'hABCD_EF12);
        tick();
        bus.iWrD_Data = 32'hCBCD_EF12; bus.iWrD_Mask = 4'b1011; bus.iWrD_EoD = 1;
        bus.iRd_Valid = 1;
        #1;
        chk("mid_busy", bus.oBusy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {bus.oRd_Ready, bus.oWr_Ready, bus.oWrD_Ready}, 0);
        chk("mid_rst_wd", {bus.oWD_Valid, bus.oWD_EoD, bus.oWD_Mask}, 0);
        chk("mid_rst_wdata", bus.oWD_Data, 0);
        chk("mid_rst_cmd", {bus.oCmd_Valid, bus.oCmd_Write, bus.oCmd_Len, bus.oCmd_Id}, 0);
        chk("mid_rst_addr", bus.oCmd_Addr, 0);
        chk("mid_rst_err", {bus.oErr_Len, bus.oBusy}, 0);
        bus.iRd_Valid = 0; bus.iWrD_Valid = 0; bus.iWrD_EoD = 0; bus.iWD_Ready = 0;
        tick();
        reset = 1'b0;
        m_rd_cnt = 0; m_wr_cnt = 0; m_rp = 1'b0; m_err = 1'b0;
        tick();
        do_txn(1, 4'd1, 0, 4'd0, 0, 2'b00, 0, 0, 0);

        // Randomized traffic with narrow QoS range to exercise ties and starvation.
        for (int i = 0; i < 60; i++) begin
            do_txn(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 3)),
                   ($urandom_range(0, 4) != 0), 4'($urandom_range(0, 3)),
                   $urandom, 2'($urandom), $urandom_range(1, 5),
                   $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
